// File: rtl/irrigation_scheduler_if.sv
// Request/actuator bundle for irrigation_scheduler.
// master: decision logic / bench side. slave: scheduler side.
// IRRIGATION_SCHED_STATS_EN adds the completed-run counter regaCount.
interface irrigation_scheduler_if;
  logic       reqGotejamento;
  logic       reqAspersao;
  logic       reqValvula;
  logic       alarmeIn;
  logic       alarmAck;
  logic       gotejamento;
  logic       aspersao;
  logic       valvulaEntrada;
  logic       alarme;
  logic [2:0] stateCode;
`ifdef IRRIGATION_SCHED_STATS_EN
  logic [7:0] regaCount;

  modport master (
    output reqGotejamento, reqAspersao, reqValvula, alarmeIn, alarmAck,
    input  gotejamento, aspersao, valvulaEntrada, alarme, stateCode, regaCount
  );
  modport slave (
    input  reqGotejamento, reqAspersao, reqValvula, alarmeIn, alarmAck,
    output gotejamento, aspersao, valvulaEntrada, alarme, stateCode, regaCount
  );
`else
  modport master (
    output reqGotejamento, reqAspersao, reqValvula, alarmeIn, alarmAck,
    input  gotejamento, aspersao, valvulaEntrada, alarme, stateCode
  );
  modport slave (
    input  reqGotejamento, reqAspersao, reqValvula, alarmeIn, alarmAck,
    output gotejamento, aspersao, valvulaEntrada, alarme, stateCode
  );
`endif
endinterface

// File: rtl/irrigation_scheduler.sv
// Irrigation sequencer: synchronises raw requests, grants one watering mode at a
// time, bounds each run, enforces a rest period and latches alarms until acked.
// Optional IRRIGATION_SCHED_STATS_EN adds a saturating completed-run counter.
module irrigation_scheduler #(
  parameter int unsigned TICK_DIV      = 1000,
  parameter int unsigned MAX_RUN_TICKS = 60,
  parameter int unsigned PAUSE_TICKS   = 10
) (
  input logic                   clk,
  input logic                   rstN,
  irrigation_scheduler_if.slave bus
);

  localparam int unsigned TimerMax = (MAX_RUN_TICKS > PAUSE_TICKS) ? MAX_RUN_TICKS : PAUSE_TICKS;
  localparam int unsigned TickW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StDrip  = 3'd1,
    StSpray = 3'd2,
    StPause = 3'd3,
    StFault = 3'd4
  } stateT;

  // Reset synchroniser: asynchronous assertion, release after two edges.
  logic [1:0] rstSyncQ;
  logic       rstSyncN;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) rstSyncQ <= 2'b00;
    else       rstSyncQ <= {rstSyncQ[0], 1'b1};
  end

  assign rstSyncN = rstSyncQ[1];

  // Two-flop synchronisers for the asynchronous request/alarm inputs.
  logic [3:0] syncMeta;
  logic [3:0] syncQ;
  logic       sGot, sAsp, sValv, sAlarme;

  always_ff @(posedge clk or negedge rstSyncN) begin
    if (!rstSyncN) begin
      syncMeta <= 4'b0000;
      syncQ    <= 4'b0000;
    end else begin
      syncMeta <= {bus.alarmeIn, bus.reqValvula, bus.reqAspersao, bus.reqGotejamento};
      syncQ    <= syncMeta;
    end
  end

  assign sGot    = syncQ[0];
  assign sAsp    = syncQ[1];
  assign sValv   = syncQ[2];
  assign sAlarme = syncQ[3];

  // Free-running tick prescaler; phase is never realigned to state changes.
  logic [TickW-1:0] tickCnt;
  logic             tick;

  assign tick = (tickCnt == TickW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rstSyncN) begin
    if (!rstSyncN)  tickCnt <= '0;
    else if (tick)  tickCnt <= '0;
    else            tickCnt <= tickCnt + 1'b1;
  end

  stateT             stateQ, stateD;
  logic [TimerW-1:0] timerQ;
  logic              runExpired;
  logic              pauseExpired;

  assign runExpired   = tick && (timerQ == TimerW'(MAX_RUN_TICKS - 1));
  assign pauseExpired = tick && (timerQ == TimerW'(PAUSE_TICKS - 1));

  // Next-state logic; alarm entry overrides every other transition.
  always_comb begin
    stateD = stateQ;
    if (sAlarme) begin
      stateD = StFault;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (sGot)      stateD = StDrip;
          else if (sAsp) stateD = StSpray;
        end
        StDrip:  if (!sGot || runExpired) stateD = StPause;
        StSpray: if (!sAsp || runExpired) stateD = StPause;
        StPause: if (pauseExpired)        stateD = StIdle;
        // sAlarme is already known low here, so an ack releases the fault.
        StFault: if (bus.alarmAck)        stateD = StPause;
        default: stateD = StIdle;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstSyncN) begin
    if (!rstSyncN) stateQ <= StIdle;
    else           stateQ <= stateD;
  end

  // Tick timer: cleared on every state entry, saturating otherwise.
  always_ff @(posedge clk or negedge rstSyncN) begin
    if (!rstSyncN)                                timerQ <= '0;
    else if (stateD != stateQ)                    timerQ <= '0;
    else if (tick && timerQ != TimerW'(TimerMax)) timerQ <= timerQ + 1'b1;
  end

  // Moore outputs registered from next-state so actuators never glitch.
  logic gotQ, aspQ, valvQ, alarmeQ;

  always_ff @(posedge clk or negedge rstSyncN) begin
    if (!rstSyncN) begin
      gotQ    <= 1'b0;
      aspQ    <= 1'b0;
      valvQ   <= 1'b0;
      alarmeQ <= 1'b0;
    end else begin
      gotQ    <= (stateD == StDrip);
      aspQ    <= (stateD == StSpray);
      valvQ   <= (stateD != StFault) && sValv;
      alarmeQ <= (stateD == StFault);
    end
  end

  assign bus.gotejamento    = gotQ;
  assign bus.aspersao       = aspQ;
  assign bus.valvulaEntrada = valvQ;
  assign bus.alarme         = alarmeQ;
  assign bus.stateCode      = stateQ;

`ifdef IRRIGATION_SCHED_STATS_EN
  logic [7:0] regaCountQ;
  logic       runDone;

  // Only a normal run end counts; fault entry bypasses PAUSE and is excluded.
  assign runDone = ((stateQ == StDrip) || (stateQ == StSpray)) && (stateD == StPause);

  // Saturating completed-run counter.
  always_ff @(posedge clk or negedge rstSyncN) begin
    if (!rstSyncN)                         regaCountQ <= 8'd0;
    else if (runDone && regaCountQ != 8'hFF) regaCountQ <= regaCountQ + 8'd1;
  end

  assign bus.regaCount = regaCountQ;
`endif

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Self-checking bench for irrigation_scheduler with a cycle-level reference model.
// Define IRRIGATION_SCHED_STATS_EN to also exercise regaCount.
module tb_irrigation_scheduler;

  localparam int TD = 4;
  localparam int MR = 3;
  localparam int PT = 2;

  localparam int IDLE  = 0;
  localparam int DRIP  = 1;
  localparam int SPRAY = 2;
  localparam int PAUSE = 3;
  localparam int FAULT = 4;

  logic clk = 1'b0;
  logic rstN = 1'b1;

  irrigation_scheduler_if bus ();

  irrigation_scheduler #(
    .TICK_DIV      (TD),
    .MAX_RUN_TICKS (MR),
    .PAUSE_TICKS   (PT)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int nErr = 0;
  int nChk = 0;

  // Reference model state
  bit inReset;
  int rstEdges;
  bit d1[4];
  bit d2[4];
  int phase;
  int mState;
  int ticksIn;
  bit eGot, eAsp, eValv, eAlm;
  int eCount;
  int runs;

  task automatic modelReset();
    inReset = 1'b1;
    rstEdges = 0;
    for (int i = 0; i < 4; i++) begin
      d1[i] = 1'b0;
      d2[i] = 1'b0;
    end
    phase = 0;
    mState = IDLE;
    ticksIn = 0;
    eGot = 1'b0; eAsp = 1'b0; eValv = 1'b0; eAlm = 1'b0;
    eCount = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic modelEdge();
    bit tick;
    int nxt;
    if (inReset) return;
    if (rstEdges < 2) begin
      rstEdges++;
      return;
    end
    tick = (phase == TD - 1);
    nxt = mState;
    if (d2[3]) nxt = FAULT;
    else begin
      case (mState)
        IDLE:  nxt = d2[0] ? DRIP : (d2[1] ? SPRAY : IDLE);
        DRIP:  if (!d2[0] || (tick && ticksIn == MR - 1)) nxt = PAUSE;
        SPRAY: if (!d2[1] || (tick && ticksIn == MR - 1)) nxt = PAUSE;
        PAUSE: if (tick && ticksIn == PT - 1) nxt = IDLE;
        FAULT: if (bus.alarmAck) nxt = PAUSE;
        default: nxt = IDLE;
      endcase
    end
    if ((mState == DRIP || mState == SPRAY) && nxt == PAUSE) begin
      runs++;
      if (eCount < 255) eCount++;
    end
    if (nxt != mState) ticksIn = 0;
    else if (tick) ticksIn++;
    eGot  = (nxt == DRIP);
    eAsp  = (nxt == SPRAY);
    eValv = (nxt != FAULT) && d2[2];
    eAlm  = (nxt == FAULT);
    mState = nxt;
    phase = (phase + 1) % TD;
    d2 = d1;
    d1[0] = bus.reqGotejamento;
    d1[1] = bus.reqAspersao;
    d1[2] = bus.reqValvula;
    d1[3] = bus.alarmeIn;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nChk++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkRange(input string tag, input int val, input int lo, input int hi);
    nChk++;
    assert (val >= lo && val <= hi) else begin
      nErr++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, val, lo, hi);
    end
  endtask

  task automatic checkAll();
    chk("gotejamento", {7'd0, bus.gotejamento}, {7'd0, eGot});
    chk("aspersao", {7'd0, bus.aspersao}, {7'd0, eAsp});
    chk("valvulaEntrada", {7'd0, bus.valvulaEntrada}, {7'd0, eValv});
    chk("alarme", {7'd0, bus.alarme}, {7'd0, eAlm});
    chk("stateCode", {5'd0, bus.stateCode}, 8'(mState));
`ifdef IRRIGATION_SCHED_STATS_EN
    chk("regaCount", bus.regaCount, 8'(eCount));
`endif
  endtask

  // One clock: edge, model update, then check at the falling edge.
  task automatic cyc();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll();
  endtask

  task automatic setIn(input bit g, input bit a, input bit v, input bit al, input bit ack);
    bus.reqGotejamento = g;
    bus.reqAspersao    = a;
    bus.reqValvula     = v;
    bus.alarmeIn       = al;
    bus.alarmAck       = ack;
  endtask

  initial begin
    int n;
    int r0;
    runs = 0;
    modelReset();
    // Reset held with every input high
    setIn(1, 1, 1, 1, 1);
    #1 rstN = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc();

    // Release with alarm and ack low so demand leads to DRIP
    setIn(1, 1, 1, 0, 0);
    rstN = 1'b1;
    inReset = 1'b0;
    n = 0;
    while (bus.stateCode !== 3'd1 && n < 20) begin cyc(); n++; end
    chkRange("reset_to_drip_edges", n, 3, 10);

    // Drip max-run, pause, then drip again
    n = 0;
    while (bus.gotejamento === 1'b1 && n < 40) begin cyc(); n++; end
    chkRange("drip_run_cycles", n, 9, 12);
    chk("after_run_state", {5'd0, bus.stateCode}, 8'd3);
    n = 0;
    while (bus.stateCode === 3'd3 && n < 40) begin cyc(); n++; end
    chkRange("pause_cycles", n, 5, 8);
    n = 0;
    while (bus.stateCode === 3'd0 && n < 10) begin cyc(); n++; end
    chk("drip_again", {5'd0, bus.stateCode}, 8'd1);

    // Priority held drip; early stop then spray after pause
    cyc(); cyc();
    bus.reqGotejamento = 1'b0;
    n = 0;
    while (bus.stateCode !== 3'd3 && n < 10) begin cyc(); n++; end
    chkRange("early_stop_edges", n, 1, 3);
    n = 0;
    while (bus.stateCode !== 3'd2 && n < 30) begin cyc(); n++; end
    chk("spray_after_pause", {5'd0, bus.stateCode}, 8'd2);

    // Fault mid-spray
    bus.alarmeIn = 1'b1;
    n = 0;
    while (bus.alarme !== 1'b1 && n < 10) begin cyc(); n++; end
    chkRange("fault_latency", n, 1, 3);
    chk("fault_asp_off", {7'd0, bus.aspersao}, 8'd0);
    chk("fault_valve_off", {7'd0, bus.valvulaEntrada}, 8'd0);
    bus.alarmAck = 1'b1; cyc();
    bus.alarmAck = 1'b0; cyc();
    chk("ack_ignored", {5'd0, bus.stateCode}, 8'd4);
    for (int i = 0; i < 6; i++) begin
      bus.reqValvula = ~bus.reqValvula;
      cyc();
      chk("fault_valve_toggle", {7'd0, bus.valvulaEntrada}, 8'd0);
    end
    bus.alarmeIn = 1'b0;
    bus.reqAspersao = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    bus.alarmAck = 1'b1; cyc();
    bus.alarmAck = 1'b0;
    chk("ack_to_pause", {5'd0, bus.stateCode}, 8'd3);
    n = 0;
    while (bus.stateCode !== 3'd0 && n < 20) begin cyc(); n++; end
    chk("pause_to_idle", {5'd0, bus.stateCode}, 8'd0);

    // Valve passthrough in idle: 3-edge latency
    bus.reqValvula = ~bus.reqValvula;
    cyc(); cyc();
    chk("valve_not_yet", {7'd0, bus.valvulaEntrada}, {7'd0, ~bus.reqValvula});
    cyc();
    chk("valve_follows", {7'd0, bus.valvulaEntrada}, {7'd0, bus.reqValvula});

    // Reset mid-run drops outputs immediately
    bus.reqGotejamento = 1'b1;
    n = 0;
    while (bus.stateCode !== 3'd1 && n < 20) begin cyc(); n++; end
    #2 rstN = 1'b0;
    #1;
    chk("async_rst_got", {7'd0, bus.gotejamento}, 8'd0);
    chk("async_rst_state", {5'd0, bus.stateCode}, 8'd0);
    modelReset();
    @(negedge clk);
    cyc();
    rstN = 1'b1;
    inReset = 1'b0;

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) bus.reqGotejamento = ~bus.reqGotejamento;
      if ($urandom_range(0, 19) == 0) bus.reqAspersao = ~bus.reqAspersao;
      if ($urandom_range(0, 5) == 0)  bus.reqValvula = ~bus.reqValvula;
      if ($urandom_range(0, 79) == 0) bus.alarmeIn = ~bus.alarmeIn;
      bus.alarmAck = ($urandom_range(0, 7) == 0);
      cyc();
    end

`ifdef IRRIGATION_SCHED_STATS_EN
    // Saturation of the run counter
    setIn(1, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc();
    bus.alarmAck = 1'b0;
    r0 = runs;
    n = 0;
    while (runs - r0 < 300 && n < 12000) begin cyc(); n++; end
    chkRange("stats_runs_done", runs - r0, 300, 300);
    chk("regaCount_saturated", bus.regaCount, 8'd255);
`else
    r0 = 0;
`endif

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
